mb_add_seq: RTL and testbench
=============================

// Module: mb_add_seq
// PURPOSE
//  Sequencer that runs one external 8-bit ripple-carry adder byte-serially to
//  add or subtract two NBYTES-wide operands, LSB byte first. Carry is registered
//  between bytes. Sits between a host/register-file (start/done handshake) and the
//  shared 8-bit adder instance; owns the adder's A/B/Cin inputs while busy.
// PARAMETERS
//  NBYTES  4  operand width in bytes (>=2); operand width W = 8*NBYTES
// PORTS
//  clk       in   1   system clock, rising edge
//  rst_n     in   1   asynchronous reset, active-low
//  start     in   1   request; sampled only in IDLE
//  sub       in   1   0 = A+B, 1 = A-B; captured with start
//  op_a      in   W   operand A; captured with start
//  op_b      in   W   operand B; captured with start
//  add_a     out  8   to adder A: current byte of captured A
//  add_b     out  8   to adder B: current byte of captured B (inverted if sub)
//  add_cin   out  1   to adder Cin: registered carry
//  add_s     in   8   from adder S (combinational, same cycle)
//  add_cout  in   1   from adder Cout (combinational, same cycle)
//  busy      out  1   high in RUN and DONE
//  done      out  1   one-cycle pulse, result valid
//  sum       out  W   result; held stable until next accepted start
//  cout      out  1   final carry out (sub: 1 = no borrow)
//  ovf       out  1   two's-complement signed overflow
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; busy, done, cout, ovf = 0; sum = 0;
//    add_a, add_b = 0, add_cin = 0; byte index and operand regs cleared.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//    IDLE: if start=1: capture op_a, op_b, sub; index=0; carry=sub; go RUN.
//    RUN: drive add_a/add_b = byte[index], add_cin = carry; at clock edge store
//      add_s into sum byte[index], carry <= add_cout, index++. After byte
//      NBYTES-1 is stored go DONE. Exactly NBYTES cycles in RUN.
//    DONE: done=1 for exactly one cycle; then IDLE.
//  - Latency: start sampled at edge 0 -> done high during cycle NBYTES+1;
//    back-to-back start accepted in the cycle after done (throughput NBYTES+2).
//  - start while busy: ignored, no effect on captured operands or result.
//  - sub=1: add_b = ~op_b byte, initial carry = 1 (A + ~B + 1).
//  - cout = add_cout of byte NBYTES-1. ovf = (a7 == b7') & (s7 != a7) on MSB
//    byte, where b7' is the effective (post-inversion) B MSB.
//  - sum/cout/ovf update byte-wise during RUN; only valid when done=1 and after
//    until the next accepted start. Clear sum to 0 on start capture.
//  - Outside RUN: add_a, add_b, add_cin driven 0 (adder idle, no toggling).
//  - Reset mid-operation: immediate abort to IDLE, all outputs to reset values;
//    no done pulse is produced for the aborted request.
//  - All widths unsigned modulo 2^W; no saturation.
// TESTING (NBYTES=4)
//  - A=0x000000FF, B=0x00000001, sub=0 -> sum 0x00000100, cout 0, ovf 0;
//    done exactly 5 cycles after start edge, busy high cycles 1..5.
//  - A=0xFFFFFFFF, B=0x00000001, sub=0 -> sum 0x00000000, cout 1, ovf 0
//    (carry ripples through all 4 bytes).
//  - A=0x7FFFFFFF, B=0x00000001, sub=0 -> sum 0x80000000, cout 0, ovf 1.
//  - A=0x00000005, B=0x00000007, sub=1 -> sum 0xFFFFFFFE, cout 0, ovf 0;
//    A=0x80000000, B=1, sub=1 -> sum 0x7FFFFFFF, cout 1, ovf 1.
//  - start pulsed with new operands in cycles 2 and 5 of a busy op -> ignored;
//    result equals first op; start in cycle after done accepted.
//  - rst_n low in cycle 3 of an op -> busy 0, sum 0, no done; next start with
//    A=1, B=2 -> sum 0x00000003 after 5 cycles.

Source files
------------

// File: rtl/mb_add_seq.sv
// rtl/mb_add_seq.sv - byte-serial add/subtract sequencer driving one shared external 8-bit adder
module mb_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sub,
  input  logic [8*NBYTES-1:0] op_a,
  input  logic [8*NBYTES-1:0] op_b,
  output logic [7:0]          add_a,
  output logic [7:0]          add_b,
  output logic                add_cin,
  input  logic [7:0]          add_s,
  input  logic                add_cout,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] sum,
  output logic                cout,
  output logic                ovf
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_rem;
  logic [W-1:0]  b_rem;
  logic [W-1:0]  b_eff;

  // Subtraction is A + ~B + 1: B is inverted once at capture, the +1 rides in as the first carry.
  assign b_eff = sub ? ~op_b : op_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      a_rem   <= '0;
      b_rem   <= '0;
      add_a   <= '0;
      add_b   <= '0;
      add_cin <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            idx     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            add_a   <= op_a[7:0];
            add_b   <= b_eff[7:0];
            add_cin <= sub;
            a_rem   <= op_a >> 8;
            b_rem   <= b_eff >> 8;
          end
        end
        RUN: begin
          sum[8*idx +: 8] <= add_s;
          idx             <= idx + 1'b1;
          if (idx == LAST) begin
            state   <= DONE;
            done    <= 1'b1;
            cout    <= add_cout;
            ovf     <= (add_a[7] == add_b[7]) && (add_s[7] != add_a[7]);
            add_a   <= '0;
            add_b   <= '0;
            add_cin <= 1'b0;
          end else begin
            // Adder inputs are registered, so the next byte is presented as this one is stored.
            add_a   <= a_rem[7:0];
            add_b   <= b_rem[7:0];
            add_cin <= add_cout;
            a_rem   <= a_rem >> 8;
            b_rem   <= b_rem >> 8;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mb_add_seq.sv
// tb/tb_mb_add_seq.sv - randomized self-checking bench for mb_add_seq against a behavioural model
module tb_mb_add_seq;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [7:0]   add_a;
  logic [7:0]   add_b;
  logic         add_cin;
  logic [7:0]   add_s;
  logic         add_cout;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  mb_add_seq #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  // The shared external 8-bit adder.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Behavioural model: accepted request, its timeline in edges, and the arithmetic result.
  int           edge_n = 0;
  int           m_e = 0;
  logic         m_active = 1'b0;
  logic [W-1:0] m_a = '0, m_b = '0;
  logic         m_sub = 1'b0;
  logic         e_busy = 1'b0, e_done = 1'b0, e_run = 1'b0, e_valid = 1'b0;
  int           e_j = 0;
  logic [W-1:0] e_sum = '0;
  logic         e_cout = 1'b0, e_ovf = 1'b0;
  longint       r_signed;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_active = 1'b0;
      e_sum = '0; e_cout = 1'b0; e_ovf = 1'b0; e_valid = 1'b1;
    end else begin
      if (m_active && edge_n == m_e + NB + 1)
        m_active = 1'b0;
      else if (!m_active && start) begin
        m_active = 1'b1; m_e = edge_n;
        m_a = op_a; m_b = op_b; m_sub = sub;
        e_sum = '0; e_cout = 1'b0; e_ovf = 1'b0; e_valid = 1'b1;
      end
      if (m_active && edge_n == m_e + 1) e_valid = 1'b0;
      if (m_active && edge_n == m_e + NB) begin
        e_sum    = m_sub ? m_a - m_b : m_a + m_b;
        e_cout   = m_sub ? (m_a >= m_b) : (({1'b0, m_a} + {1'b0, m_b}) > {1'b0, {W{1'b1}}});
        r_signed = m_sub ? longint'($signed(m_a)) - longint'($signed(m_b))
                         : longint'($signed(m_a)) + longint'($signed(m_b));
        e_ovf    = (r_signed > 64'sd2147483647) || (r_signed < -64'sd2147483648);
        e_valid  = 1'b1;
      end
    end
    e_busy = m_active;
    e_done = m_active && edge_n == m_e + NB;
    e_run  = m_active && edge_n < m_e + NB;
    e_j    = edge_n - m_e;
    edge_n++;
  end

  logic [63:0] x_beff, x_msk, x_lo, x_ea, x_eb;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sum", sum, 0);
      chk("rst_flags", {cout, ovf}, 0);
      chk("rst_adder", {add_a, add_b, add_cin}, 0);
    end else begin
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      if (e_run) begin
        x_beff = {32'd0, (m_sub ? ~m_b : m_b)};
        x_msk  = (64'd1 << (8 * e_j)) - 64'd1;
        x_lo   = ({32'd0, m_a} & x_msk) + (x_beff & x_msk) + {63'd0, m_sub};
        x_ea   = ({32'd0, m_a} >> (8 * e_j)) & 64'hFF;
        x_eb   = (x_beff >> (8 * e_j)) & 64'hFF;
        chk("add_a", add_a, x_ea);
        chk("add_b", add_b, x_eb);
        chk("add_cin", add_cin, {63'd0, x_lo[8*e_j]});
      end else begin
        chk("adder_idle", {add_a, add_b, add_cin}, 0);
      end
      if (e_valid) begin
        chk("sum", sum, e_sum);
        chk("cout", cout, e_cout);
        chk("ovf", ovf, e_ovf);
      end
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, output int lat);
    @(posedge clk); #1;
    start = 1'b1; op_a = a; op_b = b; sub = s;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    if (!done) chk("done_timeout", done, 1);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 6)
      0:       return '0;
      1:       return {W{1'b1}};
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return W'($urandom % 256);
      default: return W'($urandom);
    endcase
  endfunction

  int lat;
  int wait_n;

  initial begin
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, lat);
    chk("v1_lat", lat, 5);
    chk("v1_sum", sum, 32'h0000_0100);
    chk("v1_flags", {cout, ovf}, 2'b00);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
    chk("v2_sum", sum, 32'h0000_0000);
    chk("v2_flags", {cout, ovf}, 2'b10);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
    chk("v3_sum", sum, 32'h8000_0000);
    chk("v3_flags", {cout, ovf}, 2'b01);
    run_op(32'h0000_0005, 32'h0000_0007, 1'b1, lat);
    chk("v4_sum", sum, 32'hFFFF_FFFE);
    chk("v4_flags", {cout, ovf}, 2'b00);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, lat);
    chk("v5_sum", sum, 32'h7FFF_FFFF);
    chk("v5_flags", {cout, ovf}, 2'b11);

    // Starts during RUN and DONE are ignored; one held into the following cycle is accepted.
    @(posedge clk); #1 start = 1'b1; op_a = 32'h1122_3344; op_b = 32'h0101_0101; sub = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 start = 1'b1; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; sub = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 start = 1'b1; op_a = 32'h0000_0009; op_b = 32'h0000_0009; sub = 1'b1;
    @(negedge clk);
    chk("ign_done", done, 1);
    chk("ign_sum", sum, 32'h1223_3445);
    @(posedge clk); #1 op_a = 32'h0000_0002; op_b = 32'h0000_0003; sub = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("b2b_busy", busy, 1);
    wait_n = 0;
    while (!done && wait_n < 20) begin @(negedge clk); wait_n++; end
    chk("b2b_sum", sum, 32'h0000_0005);

    // Reset in cycle 3 of an operation aborts it.
    @(posedge clk); #1 start = 1'b1; op_a = 32'h0102_0304; op_b = 32'h1010_1010; sub = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_sum", sum, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    run_op(32'h0000_0001, 32'h0000_0002, 1'b0, lat);
    chk("post_rst_lat", lat, 5);
    chk("post_rst_sum", sum, 32'h0000_0003);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      start = (($urandom % 4) == 0);
      sub   = 1'($urandom % 2);
      op_a  = pick();
      op_b  = pick();
      rst_n = (($urandom % 700) != 0);
    end
    @(posedge clk); #1 start = 1'b0; rst_n = 1'b1;
    repeat (10) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
